jb_ifft_zero_data_insertion_nr: RTL and testbench
=================================================

Name: jb_ifft_zero_data_insertion_nr

Overview:
DL counterpart of the UL FFT zero-data removal stage. Accepts a compacted per-antenna stream of 3276 active NR subcarriers and expands it to a full 4096-point IFFT input frame, inserting zeros in guard bins 1638..2457. Adds IFFT address and per-antenna/symbol tags. Sits between the DL resource-element mapper and the IFFT core.

Parameters:
USR_ID_BW, 2, width of antenna tag
PRECISION, 16, I/Q sample width
NFFT, 4096, IFFT size (address range 0..NFFT-1)
SPACE_LOWER, 1638, first guard bin (zero inserted)
SPACE_UPPER, 2458, first active negative-frequency bin after guard

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
clk_en  in  1  clock enable; low = full freeze
input_I  in  PRECISION  active-bin I
input_Q  in  PRECISION  active-bin Q
tvalid_in  in  1  input sample valid
tready_out  out  1  block accepts input this cycle
tlast_in  in  1  last active bin of antenna symbol
antenna_in  in  USR_ID_BW  antenna of current symbol, sampled with first bin
sym_mrkr_in  in  1  symbol marker, sampled with first bin
out_ready  in  1  IFFT accepts output
output_I  out  PRECISION  IFFT input I
output_Q  out  PRECISION  IFFT input Q
address_out  out  12  IFFT bin address
dv  out  1  output valid
tfirst  out  1  high on address 0 beat
tlast  out  1  high on address NFFT-1 beat
antenna_out  out  USR_ID_BW  antenna tag, constant over frame
sym_mrkr_out  out  1  high on address 0 beat if sym_mrkr_in was captured
err_len  out  1  sticky length error, cleared by reset

Behaviour:
- Reset: state IDLE, bin counter 0, all outputs 0, tready_out 0.
- clk_en low: no transfers; tready_out forced 0; all registers hold.
- Output register advances when (!dv || out_ready); "adv" below = that condition and clk_en.
- Bin counter b (12-bit) is the address of the next output beat.
- States:
  IDLE: tready_out=1 when adv. Accepted beat -> output at address 0, tfirst=1, capture antenna_in/sym_mrkr_in, b=1, go POS.
  POS (b<SPACE_LOWER): tready_out=adv; each accepted beat -> output at b, b++. At b reaching SPACE_LOWER go ZERO.
  ZERO: tready_out=0; each adv emits I=Q=0 at b, b++; at b==SPACE_UPPER go NEG.
  NEG: tready_out=adv; accepted beat -> output at b; beat at NFFT-1 has tlast=1; then b=0, go IDLE (back-to-back frames allowed, no bubble).
  PAD: early tlast_in (input count <3276): set err_len; remaining positions emitted as zeros (guard still zero) without consuming input; final beat tlast=1; go IDLE.
  DROP: input beat 3276 arrives without tlast_in on beat 3276: set err_len; frame completes normally; keep tready_out=1, discard beats until tlast_in accepted inclusive; go IDLE.
- tlast_in on exactly the 3276th beat: normal, no error.
- Latency: accepted input appears on outputs the next cycle (1 register).
- antenna_out/sym_mrkr captured value held for whole frame; sym_mrkr_out only on address-0 beat.
- dv deasserts after a beat consumed with no new beat produced; output data holds when dv=1 and out_ready=0.
- Reset mid-frame: frame aborted, dv=0 next cycle, IDLE.

Optional Feature:
ZERO_INS_TEST_PATTERN_EN: adds input port test_mode (1 bit). When defined and test_mode=1, active-bin outputs replaced by output_I = address_out zero-extended, output_Q = 16-bit frame counter incremented at each tlast beat (wraps at 0xFFFF); guard bins remain zero; handshake unchanged. Without macro: port absent, data passes through.

Test Plan:
- One frame, 3276 beats (I=index, Q=~index), tlast on 3276th, out_ready=1 -> 4096 dv beats, addr 0..4095, bins 1638..2457 zero, addr 2458 carries input 1638, tfirst@0, tlast@4095, err_len=0.
- out_ready toggled 1/0 randomly -> identical output sequence, no lost/duplicated beats, data stable while stalled.
- Two back-to-back frames antenna 0 then 1, sym_mrkr on first -> antenna_out 0 then 1, sym_mrkr_out only on frame 0 addr 0, no bubble between frames.
- tlast_in on beat 2000 -> err_len=1, addresses 2820..4095 zero, tlast@4095.
- 3300 beats, tlast on last -> err_len=1, 4096 outputs, 24 beats dropped, next frame correct.
- Reset asserted at output addr 1000; clk_en low 10 cycles mid-frame -> dv=0 after reset/IDLE; during clk_en low tready_out=0 and outputs frozen.

Source files
------------

// File: rtl/jb_ifft_zero_data_insertion_nr_if.sv
// Stream interface of the DL IFFT zero-data insertion stage: compacted
// active-bin input from the RE mapper and full-frame output to the IFFT core.
interface jb_ifft_zero_data_insertion_nr_if #(
  parameter int USR_ID_BW = 2,
  parameter int PRECISION = 16
);
  logic [PRECISION-1:0] input_I;
  logic [PRECISION-1:0] input_Q;
  logic                 tvalid_in;
  logic                 tready_out;
  logic                 tlast_in;
  logic [USR_ID_BW-1:0] antenna_in;
  logic                 sym_mrkr_in;
  logic                 out_ready;
  logic [PRECISION-1:0] output_I;
  logic [PRECISION-1:0] output_Q;
  logic [11:0]          address_out;
  logic                 dv;
  logic                 tfirst;
  logic                 tlast;
  logic [USR_ID_BW-1:0] antenna_out;
  logic                 sym_mrkr_out;
  logic                 err_len;

  // Upstream mapper plus downstream IFFT view (drives inputs, consumes outputs)
  modport master (
    output input_I, input_Q, tvalid_in, tlast_in, antenna_in, sym_mrkr_in, out_ready,
    input  tready_out, output_I, output_Q, address_out, dv, tfirst, tlast,
    input  antenna_out, sym_mrkr_out, err_len
  );

  modport slave (
    input  input_I, input_Q, tvalid_in, tlast_in, antenna_in, sym_mrkr_in, out_ready,
    output tready_out, output_I, output_Q, address_out, dv, tfirst, tlast,
    output antenna_out, sym_mrkr_out, err_len
  );
endinterface

// File: rtl/jb_ifft_zero_data_insertion_nr.sv
// Expands a compacted stream of 3276 active NR subcarriers into a 4096-bin IFFT
// frame with a zeroed guard band. Optional feature macro: ZERO_INS_TEST_PATTERN_EN.
module jb_ifft_zero_data_insertion_nr #(
  parameter int USR_ID_BW   = 2,
  parameter int PRECISION   = 16,
  parameter int NFFT        = 4096,
  parameter int SPACE_LOWER = 1638,
  parameter int SPACE_UPPER = 2458
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
`ifdef ZERO_INS_TEST_PATTERN_EN
  input  logic test_mode,
`endif
  jb_ifft_zero_data_insertion_nr_if.slave bus
);

  localparam logic [11:0] LAST_BIN = 12'(NFFT - 1);
  localparam logic [11:0] POS_END  = 12'(SPACE_LOWER - 1);
  localparam logic [11:0] ZERO_END = 12'(SPACE_UPPER - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_POS  = 3'd1,
    S_ZERO = 3'd2,
    S_NEG  = 3'd3,
    S_PAD  = 3'd4,
    S_DROP = 3'd5
  } state_t;

  state_t               r_state;
  logic [11:0]          r_b;
  logic [PRECISION-1:0] r_out_i;
  logic [PRECISION-1:0] r_out_q;
  logic [11:0]          r_addr;
  logic                 r_dv;
  logic                 r_tfirst;
  logic                 r_tlast;
  logic [USR_ID_BW-1:0] r_ant;
  logic                 r_sym_out;
  logic                 r_err;

  logic                 w_run;
  logic                 w_adv;
  logic                 w_tready;
  logic                 w_accept;
  logic                 w_emit;
  logic                 w_fill_zero;
  logic [PRECISION-1:0] w_data_i;
  logic [PRECISION-1:0] w_data_q;

`ifdef ZERO_INS_TEST_PATTERN_EN
  logic [15:0]          r_frame_cnt;
`endif

  // Reset also blocks the input handshake so nothing is taken while clearing
  assign w_run    = clk_en & ~reset;
  assign w_adv    = w_run & (~r_dv | bus.out_ready);
  assign w_accept = bus.tvalid_in & w_tready;

  // Per-state handshake: which states take input and which ones emit a beat
  always_comb begin
    w_tready    = 1'b0;
    w_emit      = 1'b0;
    w_fill_zero = 1'b0;
    case (r_state)
      S_IDLE, S_POS, S_NEG: begin
        w_tready = w_adv;
        w_emit   = w_adv & bus.tvalid_in;
      end
      S_ZERO, S_PAD: begin
        w_emit      = w_adv;
        w_fill_zero = 1'b1;
      end
      S_DROP: begin
        w_tready = w_run;
      end
      default: begin
        w_tready = 1'b0;
      end
    endcase
  end

  // Data of the next output beat: guard/pad zeros, test pattern or input sample
  always_comb begin
    w_data_i = bus.input_I;
    w_data_q = bus.input_Q;
    if (w_fill_zero) begin
      w_data_i = {PRECISION{1'b0}};
      w_data_q = {PRECISION{1'b0}};
    end
`ifdef ZERO_INS_TEST_PATTERN_EN
    else if (test_mode) begin
      w_data_i = PRECISION'(r_b);
      w_data_q = PRECISION'(r_frame_cnt);
    end
`endif
    else begin
      w_data_i = bus.input_I;
      w_data_q = bus.input_Q;
    end
  end

  // Frame FSM, bin counter and the single output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_b       <= 12'd0;
      r_out_i   <= {PRECISION{1'b0}};
      r_out_q   <= {PRECISION{1'b0}};
      r_addr    <= 12'd0;
      r_dv      <= 1'b0;
      r_tfirst  <= 1'b0;
      r_tlast   <= 1'b0;
      r_ant     <= {USR_ID_BW{1'b0}};
      r_sym_out <= 1'b0;
      r_err     <= 1'b0;
    end else if (clk_en) begin
      if (w_emit) begin
        r_out_i   <= w_data_i;
        r_out_q   <= w_data_q;
        r_addr    <= r_b;
        r_dv      <= 1'b1;
        r_tfirst  <= (r_state == S_IDLE);
        r_tlast   <= (r_b == LAST_BIN);
        r_sym_out <= (r_state == S_IDLE) & bus.sym_mrkr_in;
        r_b       <= (r_b == LAST_BIN) ? 12'd0 : r_b + 12'd1;
      end else if (w_adv) begin
        r_dv      <= 1'b0;
        r_tfirst  <= 1'b0;
        r_tlast   <= 1'b0;
        r_sym_out <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ant <= bus.antenna_in;
            if (bus.tlast_in) begin
              r_err   <= 1'b1;
              r_state <= S_PAD;
            end else begin
              r_state <= S_POS;
            end
          end
        end
        S_POS: begin
          if (w_accept) begin
            if (bus.tlast_in) begin
              r_err   <= 1'b1;
              r_state <= S_PAD;
            end else if (r_b == POS_END) begin
              r_state <= S_ZERO;
            end
          end
        end
        S_ZERO: begin
          if (w_emit && (r_b == ZERO_END)) begin
            r_state <= S_NEG;
          end
        end
        S_NEG: begin
          // Bin NFFT-1 is the 3276th input; tlast_in must line up with it
          if (w_accept) begin
            if (r_b == LAST_BIN) begin
              if (bus.tlast_in) begin
                r_state <= S_IDLE;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_DROP;
              end
            end else if (bus.tlast_in) begin
              r_err   <= 1'b1;
              r_state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          if (w_emit && (r_b == LAST_BIN)) begin
            r_state <= S_IDLE;
          end
        end
        S_DROP: begin
          if (w_accept && bus.tlast_in) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ZERO_INS_TEST_PATTERN_EN
  // Test-pattern frame counter, stepped on every final-bin beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= 16'd0;
    end else if (clk_en && w_emit && (r_b == LAST_BIN)) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end
`endif

  assign bus.tready_out   = w_tready;
  assign bus.output_I     = r_out_i;
  assign bus.output_Q     = r_out_q;
  assign bus.address_out  = r_addr;
  assign bus.dv           = r_dv;
  assign bus.tfirst       = r_tfirst;
  assign bus.tlast        = r_tlast;
  assign bus.antenna_out  = r_ant;
  assign bus.sym_mrkr_out = r_sym_out;
  assign bus.err_len      = r_err;

endmodule

// File: tb/tb_jb_ifft_zero_data_insertion_nr.sv
// Directed self-checking bench for jb_ifft_zero_data_insertion_nr: full frames,
// backpressure, back-to-back, short/long frames, mid-frame reset and clk_en freeze.
module tb_jb_ifft_zero_data_insertion_nr;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        last;
    logic [1:0]  ant;
    logic        sym;
  } in_t;

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] i;
    logic [15:0] q;
    logic        dv;
    logic        tfirst;
    logic        tlast;
    logic [1:0]  ant;
    logic        sym;
  } out_t;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;
`ifdef ZERO_INS_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  in_t  in_q[$];
  out_t out_q[$];
  int   stall_bad;
  int   freeze_bad;
  int   iters;
  int   n_acc;

  jb_ifft_zero_data_insertion_nr_if #(.USR_ID_BW(2), .PRECISION(16)) bus ();

  jb_ifft_zero_data_insertion_nr #(
    .USR_ID_BW(2), .PRECISION(16), .NFFT(4096), .SPACE_LOWER(1638), .SPACE_UPPER(2458)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clk_en(clk_en),
`ifdef ZERO_INS_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Expected sample at bin a when only the first n_valid inputs are real data
  function automatic logic [15:0] exp_i(input int a, input int n_valid);
    int idx;
    if (a >= 1638 && a < 2458) return 16'h0000;
    idx = (a < 1638) ? a : a - 820;
    if (idx >= n_valid) return 16'h0000;
    return 16'(idx);
  endfunction

  function automatic logic [15:0] exp_q(input int a, input int n_valid);
    int idx;
    if (a >= 1638 && a < 2458) return 16'h0000;
    idx = (a < 1638) ? a : a - 820;
    if (idx >= n_valid) return 16'h0000;
    return ~16'(idx);
  endfunction

  task automatic add_frame(input int n, input int last_idx, input logic [1:0] ant, input logic sym);
    in_t b;
    for (int k = 0; k < n; k++) begin
      b.i = 16'(k);
      b.q = ~16'(k);
      b.last = (k == last_idx);
      b.ant = ant;
      b.sym = sym;
      in_q.push_back(b);
    end
  endtask

  function automatic out_t snap();
    out_t o;
    o.addr = bus.address_out; o.i = bus.output_I; o.q = bus.output_Q;
    o.dv = bus.dv; o.tfirst = bus.tfirst; o.tlast = bus.tlast;
    o.ant = bus.antenna_out; o.sym = bus.sym_mrkr_out;
    return o;
  endfunction

  // Streams in_q into the DUT and collects n_out consumed beats (bounded)
  task automatic run_stream(input int n_out, input bit rnd_ready, input int gap_at);
    int   it = 0;
    int   ii = 0;
    bit   acc;
    bit   stalled_prev = 1'b0;
    bit   prev_en = 1'b1;
    out_t prev_o = '0;
    out_t cur;
    out_q.delete();
    stall_bad = 0;
    freeze_bad = 0;
    while (out_q.size() < n_out && it < 30000) begin
      @(negedge clk);
      clk_en = !(gap_at >= 0 && it >= gap_at && it < gap_at + 10);
      bus.out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
      if (ii < in_q.size()) begin
        bus.tvalid_in = 1'b1;
        bus.input_I = in_q[ii].i;
        bus.input_Q = in_q[ii].q;
        bus.tlast_in = in_q[ii].last;
        bus.antenna_in = in_q[ii].ant;
        bus.sym_mrkr_in = in_q[ii].sym;
      end else begin
        bus.tvalid_in = 1'b0;
        bus.tlast_in = 1'b0;
      end
      #1;
      cur = snap();
      if (!clk_en) begin
        if (bus.tready_out !== 1'b0) freeze_bad++;
        if (!prev_en && cur !== prev_o) freeze_bad++;
      end
      if (stalled_prev && cur !== prev_o) stall_bad++;
      acc = bus.tvalid_in && bus.tready_out;
      if (clk_en && bus.dv && bus.out_ready) out_q.push_back(cur);
      stalled_prev = clk_en && bus.dv && !bus.out_ready;
      prev_en = clk_en;
      prev_o = cur;
      @(posedge clk);
      if (acc) ii++;
      it++;
    end
    iters = it;
    n_acc = ii;
    @(negedge clk);
    bus.tvalid_in = 1'b0;
    bus.tlast_in = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (bus.dv !== 1'b0) $display("FAIL reset_dv: got %b want 0", bus.dv); else n_pass++;
    n_chk++; if (bus.tready_out !== 1'b0) $display("FAIL reset_tready: got %b want 0", bus.tready_out); else n_pass++;
    n_chk++; if (bus.address_out !== 12'd0) $display("FAIL reset_addr: got %0d want 0", bus.address_out); else n_pass++;
    n_chk++; if (bus.err_len !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err_len); else n_pass++;
    n_chk++; if ({bus.tfirst, bus.tlast, bus.sym_mrkr_out, bus.antenna_out} !== 5'd0)
      $display("FAIL reset_flags: got %b want 0", {bus.tfirst, bus.tlast, bus.sym_mrkr_out, bus.antenna_out}); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if (bus.tready_out !== 1'b1) $display("FAIL idle_tready: got %b want 1", bus.tready_out); else n_pass++;
  endtask

  task automatic test_full_frame();
    int bad = 0;
    in_q.delete();
    add_frame(3276, 3275, 2'd3, 1'b1);
    run_stream(4096, 1'b0, -1);
    for (int a = 0; a < out_q.size(); a++) begin
      if (out_q[a].addr !== 12'(a)) bad++;
      if (out_q[a].i !== exp_i(a, 3276) || out_q[a].q !== exp_q(a, 3276)) bad++;
      if (out_q[a].tfirst !== (a == 0) || out_q[a].tlast !== (a == 4095)) bad++;
    end
    n_chk++; if (out_q.size() != 4096) $display("FAIL full_count: got %0d want 4096", out_q.size()); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL full_data: got %0d bad beats want 0", bad); else n_pass++;
    n_chk++; if (out_q[2458].i !== 16'd1638) $display("FAIL full_addr2458: got %0d want 1638", out_q[2458].i); else n_pass++;
    n_chk++; if (out_q[1638].i !== 16'd0) $display("FAIL full_guard1638: got %0d want 0", out_q[1638].i); else n_pass++;
    n_chk++; if (out_q[2457].q !== 16'd0) $display("FAIL full_guard2457: got %0d want 0", out_q[2457].q); else n_pass++;
    n_chk++; if (out_q[1637].i !== 16'd1637) $display("FAIL full_addr1637: got %0d want 1637", out_q[1637].i); else n_pass++;
    n_chk++; if (iters != 4097) $display("FAIL full_cycles: got %0d want 4097", iters); else n_pass++;
    n_chk++; if (out_q[0].ant !== 2'd3 || out_q[4095].ant !== 2'd3) $display("FAIL full_ant: got %0d want 3", out_q[4095].ant); else n_pass++;
    n_chk++; if (bus.err_len !== 1'b0) $display("FAIL full_err: got %b want 0", bus.err_len); else n_pass++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    in_q.delete();
    add_frame(3276, 3275, 2'd1, 1'b0);
    run_stream(4096, 1'b1, -1);
    for (int a = 0; a < out_q.size(); a++) begin
      if (out_q[a].addr !== 12'(a)) bad++;
      if (out_q[a].i !== exp_i(a, 3276) || out_q[a].q !== exp_q(a, 3276)) bad++;
    end
    n_chk++; if (out_q.size() != 4096) $display("FAIL bp_count: got %0d want 4096", out_q.size()); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL bp_data: got %0d bad beats want 0", bad); else n_pass++;
    n_chk++; if (stall_bad != 0) $display("FAIL bp_stall_stable: got %0d changes want 0", stall_bad); else n_pass++;
    n_chk++; if (n_acc != 3276) $display("FAIL bp_accepted: got %0d want 3276", n_acc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    int syms = 0;
    in_q.delete();
    add_frame(3276, 3275, 2'd0, 1'b1);
    add_frame(3276, 3275, 2'd1, 1'b0);
    run_stream(8192, 1'b0, -1);
    for (int a = 0; a < out_q.size(); a++) begin
      if (out_q[a].addr !== 12'(a % 4096)) bad++;
      if (out_q[a].i !== exp_i(a % 4096, 3276)) bad++;
      if (out_q[a].ant !== ((a < 4096) ? 2'd0 : 2'd1)) bad++;
      if (out_q[a].sym) syms++;
    end
    n_chk++; if (out_q.size() != 8192) $display("FAIL b2b_count: got %0d want 8192", out_q.size()); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL b2b_data: got %0d bad beats want 0", bad); else n_pass++;
    n_chk++; if (iters != 8193) $display("FAIL b2b_no_bubble: got %0d cycles want 8193", iters); else n_pass++;
    n_chk++; if (out_q[0].sym !== 1'b1 || syms != 1) $display("FAIL b2b_sym: got %0d markers want 1 at addr 0", syms); else n_pass++;
    n_chk++; if (out_q[4096].tfirst !== 1'b1) $display("FAIL b2b_tfirst2: got %b want 1", out_q[4096].tfirst); else n_pass++;
  endtask

  task automatic test_early_tlast();
    int bad = 0;
    in_q.delete();
    add_frame(2000, 1999, 2'd2, 1'b0);
    run_stream(4096, 1'b0, -1);
    for (int a = 0; a < out_q.size(); a++) begin
      if (out_q[a].addr !== 12'(a)) bad++;
      if (out_q[a].i !== exp_i(a, 2000) || out_q[a].q !== exp_q(a, 2000)) bad++;
      if (out_q[a].tlast !== (a == 4095)) bad++;
    end
    n_chk++; if (out_q.size() != 4096) $display("FAIL short_count: got %0d want 4096", out_q.size()); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL short_data: got %0d bad beats want 0", bad); else n_pass++;
    n_chk++; if (out_q[2819].i !== 16'd1999) $display("FAIL short_last_data: got %0d want 1999", out_q[2819].i); else n_pass++;
    n_chk++; if (out_q[2820].q !== 16'd0) $display("FAIL short_pad: got %0d want 0", out_q[2820].q); else n_pass++;
    n_chk++; if (bus.err_len !== 1'b1) $display("FAIL short_err: got %b want 1", bus.err_len); else n_pass++;
    n_chk++; if (bus.tready_out !== 1'b1) $display("FAIL short_idle: got %b want 1", bus.tready_out); else n_pass++;
  endtask

  task automatic test_drop();
    int bad = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    n_chk++; if (bus.err_len !== 1'b0) $display("FAIL drop_err_cleared: got %b want 0", bus.err_len); else n_pass++;
    in_q.delete();
    add_frame(3300, 3299, 2'd1, 1'b0);
    add_frame(3276, 3275, 2'd2, 1'b0);
    run_stream(8192, 1'b0, -1);
    for (int a = 0; a < out_q.size(); a++) begin
      if (out_q[a].addr !== 12'(a % 4096)) bad++;
      if (out_q[a].i !== exp_i(a % 4096, 3276) || out_q[a].q !== exp_q(a % 4096, 3276)) bad++;
    end
    n_chk++; if (out_q.size() != 8192) $display("FAIL drop_count: got %0d want 8192", out_q.size()); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL drop_data: got %0d bad beats want 0", bad); else n_pass++;
    n_chk++; if (n_acc != 6576) $display("FAIL drop_accepted: got %0d want 6576", n_acc); else n_pass++;
    n_chk++; if (out_q[4096].ant !== 2'd2) $display("FAIL drop_next_ant: got %0d want 2", out_q[4096].ant); else n_pass++;
    n_chk++; if (bus.err_len !== 1'b1) $display("FAIL drop_err: got %b want 1", bus.err_len); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int bad = 0;
    in_q.delete();
    add_frame(3276, 3275, 2'd2, 1'b0);
    run_stream(1001, 1'b0, -1);
    n_chk++; if (out_q[1000].addr !== 12'd1000) $display("FAIL mid_addr1000: got %0d want 1000", out_q[1000].addr); else n_pass++;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (bus.dv !== 1'b0) $display("FAIL mid_rst_dv: got %b want 0", bus.dv); else n_pass++;
    n_chk++; if (bus.err_len !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", bus.err_len); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++; if (bus.tready_out !== 1'b1) $display("FAIL mid_rst_idle: got %b want 1", bus.tready_out); else n_pass++;
    in_q.delete();
    add_frame(3276, 3275, 2'd1, 1'b1);
    run_stream(4096, 1'b0, 500);
    for (int a = 0; a < out_q.size(); a++) begin
      if (out_q[a].addr !== 12'(a)) bad++;
      if (out_q[a].i !== exp_i(a, 3276) || out_q[a].q !== exp_q(a, 3276)) bad++;
    end
    n_chk++; if (out_q.size() != 4096) $display("FAIL en_count: got %0d want 4096", out_q.size()); else n_pass++;
    n_chk++; if (bad != 0) $display("FAIL en_data: got %0d bad beats want 0", bad); else n_pass++;
    n_chk++; if (freeze_bad != 0) $display("FAIL en_freeze: got %0d violations want 0", freeze_bad); else n_pass++;
    n_chk++; if (iters != 4107) $display("FAIL en_cycles: got %0d want 4107", iters); else n_pass++;
  endtask

  initial begin
    bus.input_I = 16'd0;
    bus.input_Q = 16'd0;
    bus.tvalid_in = 1'b0;
    bus.tlast_in = 1'b0;
    bus.antenna_in = 2'd0;
    bus.sym_mrkr_in = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_back_to_back();
    test_early_tlast();
    test_drop();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
